// File: rtl/brus16_mem_pkg.sv
// Shared types and helpers for the brus16 simple dual-port RAM.
// Functions work on MAX_W-bit words; callers zero-extend and truncate to their own width.
package brus16_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  localparam int MAX_W      = 64;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W       = DATA_W_DEF / 8;

  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]   old_w,
                                                input logic [MAX_W-1:0]   new_w,
                                                input logic [MAX_W/8-1:0] be);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_W / 8; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Even parity: the stored bit makes each byte plus parity carry an even count of ones.
  function automatic logic [MAX_W/8-1:0] byte_parity(input logic [MAX_W-1:0] data);
    logic [MAX_W/8-1:0] par;
    for (int i = 0; i < MAX_W / 8; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/brus16_sdp_ram_core.sv
// Bare inferred simple dual-port array: per-lane write enables, registered read, no reset.
module brus16_sdp_ram_core #(
  parameter int LANE_W = 8,
  parameter int NLANES = 2,
  parameter int DEPTH  = 8192,
  parameter int IDX_W  = 13
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [LANE_W*NLANES-1:0] wr_data_i,
  input  logic [NLANES-1:0]        wr_be_i,
  input  logic                     rd_en_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [LANE_W*NLANES-1:0] rd_data_o
);

  localparam int W = LANE_W * NLANES;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  // Lane-masked array write
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wr_be_i[i]) begin
          mem_q[wr_idx_i][i*LANE_W +: LANE_W] <= wr_data_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read returns the pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/brus16_sdp_ram.sv
// brus16 simple dual-port RAM: byte enables, 1/2-cycle read latency, RDW policy, clear sequencer.
// Optional per-byte parity with par_err output when BRUS16_SDP_RAM_PARITY_EN is defined.
module brus16_sdp_ram #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 13,
  parameter int                DEPTH          = 8192,
  parameter int                READ_LATENCY   = 1,
  parameter int                RDW_MODE       = 0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = {DATA_W{1'b0}},
  parameter int                CLEAR_ON_RESET = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
`ifdef BRUS16_SDP_RAM_PARITY_EN
  ,output logic               par_err
`endif
);

  import brus16_mem_pkg::*;

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MBE   = MAX_W / 8;
  localparam int AW1   = ADDR_W + 1;
`ifdef BRUS16_SDP_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int                CW       = LANE_W * NB;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = AW1'(DEPTH);

  clr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              idle_s, sweep_s, wr_acc_s, wr_inr_s, rd_acc_s, rd_inr_s, fwd_hit_s;
  logic              core_we_s;
  logic [IDX_W-1:0]  core_widx_s;
  logic [NB-1:0]     core_wbe_s;
  logic [CW-1:0]     wr_lanes_s, clr_lanes_s, core_wdata_s, core_rdata_s;
  logic [DATA_W-1:0] rd_bytes_s, merged_s, data1_s;
  logic              v1_q, inr1_q, v2_q, rd_valid_q;
  logic [NB-1:0]     fbe1_q;
  logic [DATA_W-1:0] fdata1_q, d2_q, rd_data_q;
`ifdef BRUS16_SDP_RAM_PARITY_EN
  logic [NB-1:0]     wr_par_s, clr_par_s, rd_par_s;
  logic              pe1_s, pe2_q, par_q;
`endif

  // Clear sequencer state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign idle_s    = (state_q == ST_IDLE);
  assign sweep_s   = (state_q == ST_CLEAR);
  assign wr_ready  = idle_s;
  assign rd_ready  = idle_s;
  assign clr_busy  = sweep_s;
  assign clr_done  = (state_q == ST_DONE);
  assign wr_acc_s  = wr_en & idle_s;
  assign rd_acc_s  = rd_en & idle_s;
  assign wr_inr_s  = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_inr_s  = ({1'b0, rd_addr} < DEPTH_X);
  assign fwd_hit_s = (RDW_MODE == 1) && wr_acc_s && wr_inr_s && (wr_addr == rd_addr);

`ifdef BRUS16_SDP_RAM_PARITY_EN
  assign wr_par_s  = NB'(byte_parity(MAX_W'(wr_data)));
  assign clr_par_s = NB'(byte_parity(MAX_W'(CLEAR_VALUE)));
`endif

  // Byte <-> storage lane mapping (lane = optional parity bit above the byte)
  always_comb begin
    wr_lanes_s  = {CW{1'b0}};
    clr_lanes_s = {CW{1'b0}};
    rd_bytes_s  = {DATA_W{1'b0}};
`ifdef BRUS16_SDP_RAM_PARITY_EN
    rd_par_s    = {NB{1'b0}};
`endif
    for (int i = 0; i < NB; i++) begin
`ifdef BRUS16_SDP_RAM_PARITY_EN
      wr_lanes_s[i*LANE_W +: LANE_W]  = {wr_par_s[i], wr_data[8*i +: 8]};
      clr_lanes_s[i*LANE_W +: LANE_W] = {clr_par_s[i], CLEAR_VALUE[8*i +: 8]};
      rd_par_s[i]                     = core_rdata_s[i*LANE_W + 8];
`else
      wr_lanes_s[i*LANE_W +: LANE_W]  = wr_data[8*i +: 8];
      clr_lanes_s[i*LANE_W +: LANE_W] = CLEAR_VALUE[8*i +: 8];
`endif
      rd_bytes_s[8*i +: 8] = core_rdata_s[i*LANE_W +: 8];
    end
  end

  // Sweep owns the write port while clearing; out-of-range user writes are dropped
  always_comb begin
    if (sweep_s) begin
      core_we_s    = resetn;
      core_widx_s  = cnt_q;
      core_wdata_s = clr_lanes_s;
      core_wbe_s   = {NB{1'b1}};
    end else begin
      core_we_s    = resetn & wr_acc_s & wr_inr_s;
      core_widx_s  = wr_addr[IDX_W-1:0];
      core_wdata_s = wr_lanes_s;
      core_wbe_s   = wr_be;
    end
  end

  brus16_sdp_ram_core #(
    .LANE_W (LANE_W),
    .NLANES (NB),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk       (clk),
    .wr_en_i   (core_we_s),
    .wr_idx_i  (core_widx_s),
    .wr_data_i (core_wdata_s),
    .wr_be_i   (core_wbe_s),
    .rd_en_i   (rd_acc_s),
    .rd_idx_i  (rd_addr[IDX_W-1:0]),
    .rd_data_o (core_rdata_s)
  );

  // Side-band for the read in flight: range flag and bytes to forward from a colliding write
  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1_q     <= 1'b0;
      inr1_q   <= 1'b0;
      fbe1_q   <= {NB{1'b0}};
      fdata1_q <= {DATA_W{1'b0}};
    end else begin
      v1_q <= rd_acc_s;
      if (rd_acc_s) begin
        inr1_q   <= rd_inr_s;
        fbe1_q   <= fwd_hit_s ? wr_be : {NB{1'b0}};
        fdata1_q <= wr_data;
      end
    end
  end

  assign merged_s = DATA_W'(be_merge(MAX_W'(rd_bytes_s), MAX_W'(fdata1_q), MBE'(fbe1_q)));
  assign data1_s  = inr1_q ? merged_s : {DATA_W{1'b0}};
`ifdef BRUS16_SDP_RAM_PARITY_EN
  // Forwarded bytes carry freshly computed parity, so only stored bytes can flag an error
  assign pe1_s = inr1_q & (|((rd_par_s ^ NB'(byte_parity(MAX_W'(rd_bytes_s)))) & ~fbe1_q));
`endif

  // Optional OCE stage and the output registers; rd_data holds between valid beats
  always_ff @(posedge clk) begin
    if (!resetn) begin
      v2_q       <= 1'b0;
      d2_q       <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
`ifdef BRUS16_SDP_RAM_PARITY_EN
      pe2_q      <= 1'b0;
      par_q      <= 1'b0;
`endif
    end else begin
      v2_q <= v1_q;
      d2_q <= data1_s;
`ifdef BRUS16_SDP_RAM_PARITY_EN
      pe2_q <= pe1_s;
`endif
      if (READ_LATENCY == 2) begin
        rd_valid_q <= v2_q;
        if (v2_q) begin
          rd_data_q <= d2_q;
        end
`ifdef BRUS16_SDP_RAM_PARITY_EN
        par_q <= v2_q & pe2_q;
`endif
      end else begin
        rd_valid_q <= v1_q;
        if (v1_q) begin
          rd_data_q <= data1_s;
        end
`ifdef BRUS16_SDP_RAM_PARITY_EN
        par_q <= v1_q & pe1_s;
`endif
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`ifdef BRUS16_SDP_RAM_PARITY_EN
  assign par_err  = par_q;
`endif

endmodule
